// File: rtl/gf_reduce_seq.sv
// ---------------------------------------------------------------------------
// gf_reduce_seq
//
// Sequential GF(2^m) modular reduction stage. Takes a 2*DATA_WIDTH-bit
// carry-less product and reduces it modulo P = x^DATA_WIDTH + in_poly,
// clearing one product bit per clock from the top down. DATA_WIDTH cycles
// after a request is accepted the remainder appears on out_rem together
// with a one-cycle out_done pulse.
//
// Ports:
//   clk       rising-edge system clock
//   rst       synchronous, active-high reset
//   in_start  request, accepted only while out_busy is low
//   in_prod   2*DATA_WIDTH-bit carry-less product, captured on accept
//   in_poly   low coefficients of P (leading 1 implicit), captured on accept
//   out_busy  high while a reduction is running
//   out_done  one-cycle pulse when out_rem has been updated
//   out_rem   in_prod mod P, held until the next completion
// ---------------------------------------------------------------------------
module gf_reduce_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_start,
    input  logic [2*DATA_WIDTH-1:0] in_prod,
    input  logic [DATA_WIDTH-1:0]   in_poly,
    output logic                    out_busy,
    output logic                    out_done,
    output logic [DATA_WIDTH-1:0]   out_rem
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [PW-1:0]         r_q;
    logic [PW-1:0]         r_next;
    logic [PW-1:0]         lead_mask;
    logic [PW-1:0]         poly_sh;
    logic [DATA_WIDTH-1:0] poly_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [CW-1:0]         cnt_q;
    logic                  accept;
    logic                  finish;
    logic                  lead_set;

    // The bit under examination is i = PW-1-cnt. Aligning the full
    // polynomial {1,poly} so its leading 1 sits on bit i means shifting it
    // by i-DATA_WIDTH = DATA_WIDTH-1-cnt; the XOR then clears bit i and
    // only disturbs bits i..i-DATA_WIDTH.
    assign lead_mask = {1'b1, {(PW-1){1'b0}}} >> cnt_q;
    assign poly_sh   = {{(DATA_WIDTH-1){1'b0}}, 1'b1, poly_q} << (LAST_CNT - cnt_q);
    assign lead_set  = |(r_q & lead_mask);
    assign r_next    = lead_set ? (r_q ^ poly_sh) : r_q;
    assign out_rem   = rem_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode. DONE may accept a new request in
    // the same cycle so that a held in_start gives back-to-back operation.
    always_comb begin
        state_d  = state_q;
        out_busy = 1'b0;
        out_done = 1'b0;
        accept   = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                out_busy = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_done = 1'b1;
                if (in_start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, clear one product bit per RUN
    // cycle, and publish the low half of the working register on the last
    // iteration. Requests seen while running never reach this block
    // because accept is only raised in IDLE or DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            poly_q <= '0;
            cnt_q  <= '0;
            rem_q  <= '0;
        end else if (accept) begin
            r_q    <= in_prod;
            poly_q <= in_poly;
            cnt_q  <= '0;
        end else if (state_q == RUN) begin
            r_q   <= r_next;
            cnt_q <= cnt_q + CW'(1);
            if (finish) begin
                rem_q <= r_next[DATA_WIDTH-1:0];
            end
        end
    end

endmodule
